// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: one outstanding instruction-memory request at a time,
// fetched word handed to decode over valid/ready, PC advanced only on acceptance.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        jump_sig,
    input  logic [31:0] jump_off,
    output logic [31:0] fetch_cnt
);

    localparam int unsigned W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t       state;
    logic [W-1:0] next_pc;

    // Sequential PC, or PC-relative word jump; shift discards jump_off[31:30].
    always_comb begin
        next_pc = pc + W'(4);
        if (jump_sig) begin
            next_pc = pc + W'(4) + (jump_off << 2);
        end
    end

    // The request address is the architectural PC itself.
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            fetch_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    imem_req <= 1'b1;
                    state    <= REQ;
                end
                REQ: begin
                    if (imem_ack) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= next_pc;
                        fetch_cnt   <= fetch_cnt + W'(1);
                        imem_req    <= 1'b1;
                        state       <= REQ;
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected fetch addresses queued when each
// handshake is driven and popped when the next request appears.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_ready;
    logic        jump_sig;
    logic [31:0] jump_off;

    logic [31:0] m_pc, m_addr, m_instr, m_cnt;
    logic        m_req, m_valid;
    logic [31:0] w_pc, w_addr, w_instr, w_cnt;
    logic        w_req, w_valid;

    logic        sel;
    logic [31:0] o_pc, o_addr, o_instr, o_cnt, o_reset_pc;
    logic        o_req, o_valid;

    int          checks;
    int          failures;
    logic [31:0] exp_q[$];
    logic [31:0] exp_cnt;

    fetch_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .pc(m_pc), .imem_req(m_req), .imem_addr(m_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(m_instr),
        .instr_valid(m_valid), .instr_ready(instr_ready), .jump_sig(jump_sig),
        .jump_off(jump_off), .fetch_cnt(m_cnt)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .pc(w_pc), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(w_instr),
        .instr_valid(w_valid), .instr_ready(instr_ready), .jump_sig(jump_sig),
        .jump_off(jump_off), .fetch_cnt(w_cnt)
    );

    // Both instances see the same stimulus; sel picks which one is observed.
    always_comb begin
        o_pc       = sel ? w_pc    : m_pc;
        o_addr     = sel ? w_addr  : m_addr;
        o_instr    = sel ? w_instr : m_instr;
        o_cnt      = sel ? w_cnt   : m_cnt;
        o_req      = sel ? w_req   : m_req;
        o_valid    = sel ? w_valid : m_valid;
        o_reset_pc = sel ? 32'hFFFF_FFF8 : 32'h0000_0000;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset for two edges (with a colliding ack), then release with a late ack in IDLE.
    task automatic do_reset();
        rst_n       = 1'b0;
        imem_ack    = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b1;
        jump_sig    = 1'b1;
        jump_off    = 32'h0000_0010;
        step();
        chk("rst_req", 32'(o_req), 32'd0);
        chk("rst_pc", o_pc, o_reset_pc);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_cnt", o_cnt, 32'd0);
        step();
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_req2", 32'(o_req), 32'd0);
        rst_n       = 1'b1;
        instr_ready = 1'b0;
        jump_sig    = 1'b0;
        step();
        imem_ack = 1'b0;
        chk("rel_req", 32'(o_req), 32'd1);
        chk("rel_valid", 32'(o_valid), 32'd0);
        chk("rel_pc", o_pc, o_reset_pc);
        exp_q.delete();
        exp_q.push_back(o_reset_pc);
        exp_cnt = 32'd0;
    endtask

    // One fetch: wait states, capture, decode stall with stray inputs, handshake.
    task automatic fetch_one(input int waits, input int stall,
                             input logic jmp, input logic [31:0] off);
        int          n;
        logic [31:0] exp;
        logic [31:0] nexp;
        n = 0;
        while (o_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 32'(o_req), 32'd1);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        chk("addr", o_addr, exp);
        chk("pc", o_pc, exp);
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            step();
            chk("wait_req", 32'(o_req), 32'd1);
            chk("wait_addr", o_addr, exp);
            chk("wait_valid", 32'(o_valid), 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = mem_word(exp);
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("cap_valid", 32'(o_valid), 32'd1);
        chk("cap_instr", o_instr, mem_word(exp));
        chk("cap_req", 32'(o_req), 32'd0);
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            jump_sig    = 1'b1;
            jump_off    = $urandom;
            imem_ack    = 1'b1;
            step();
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_instr", o_instr, mem_word(exp));
            chk("stall_req", 32'(o_req), 32'd0);
            chk("stall_pc", o_pc, exp);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        jump_sig    = jmp;
        jump_off    = off;
        nexp = jmp ? (exp + 32'd4 + {off[29:0], 2'b00}) : (exp + 32'd4);
        exp_q.push_back(nexp);
        exp_cnt = exp_cnt + 32'd1;
        step();
        instr_ready = 1'b0;
        jump_sig    = 1'b0;
        chk("hs_valid", 32'(o_valid), 32'd0);
        chk("hs_cnt", o_cnt, exp_cnt);
        chk("hs_pc", o_pc, nexp);
        chk("hs_req", 32'(o_req), 32'd1);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_cnt     = 32'd0;
        sel         = 1'b0;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        jump_sig    = 1'b0;
        jump_off    = 32'd0;

        do_reset();
        fetch_one(0, 0, 1'b0, 32'd0);
        fetch_one(0, 0, 1'b0, 32'd0);
        fetch_one(0, 0, 1'b0, 32'd0);
        chk("cnt_after3", o_cnt, 32'd3);
        chk("addr_12", o_addr, 32'd12);
        fetch_one(0, 0, 1'b1, 32'hFFFF_FFFE);
        fetch_one(0, 0, 1'b1, 32'd3);
        fetch_one(0, 0, 1'b1, 32'hFFFF_FFFB);
        fetch_one(3, 0, 1'b0, 32'd0);
        fetch_one(1, 5, 1'b0, 32'd0);
        chk("after_stall_pc", o_pc, 32'd16);

        // Reset while a request to 16 is outstanding.
        imem_ack = 1'b0;
        step();
        chk("pend_req", 32'(o_req), 32'd1);
        do_reset();
        fetch_one(0, 0, 1'b0, 32'd0);
        fetch_one(2, 1, 1'b1, 32'h3FFF_FFFF);

        // Wrap-around from RESET_PC = FFFF_FFF8.
        sel = 1'b1;
        do_reset();
        fetch_one(0, 0, 1'b0, 32'd0);
        fetch_one(0, 0, 1'b0, 32'd0);
        fetch_one(0, 0, 1'b0, 32'd0);
        chk("wrap_cnt", o_cnt, 32'd3);
        chk("wrap_pc", o_pc, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
